// File: rtl/cpu_pkg.sv
// Shared fetch-stage types and constants: fetch FSM state encoding, bubble
// instruction word and instruction size.
package cpu_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    ERR  = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR       = 32'h0000_0000;
  localparam int unsigned INSTR_BYTES     = 4;
  localparam logic [31:0] ADDR_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory bus between the fetch unit (master) and instruction memory (slave).
interface if_fetch_unit_if;

  // A request is accepted in a cycle where imem_req_o and imem_gnt_i are both 1;
  // imem_addr_o is meaningful only while imem_req_o is 1 and may change while
  // ungranted. Each accepted request returns exactly one imem_rvalid_i pulse, at
  // least one cycle after the grant; imem_rdata_i is valid only with imem_rvalid_i.
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_gnt_i,
    input  imem_rvalid_i,
    input  imem_rdata_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_gnt_i,
    output imem_rvalid_i,
    output imem_rdata_i
  );

endinterface

// File: rtl/if_pc_gen.sv
// Program counter register with next-PC selection: reset / redirect / +4 / hold.
module if_pc_gen
  import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] load_pc,
    input  logic        advance,
    output logic [31:0] pc
);

    localparam logic [31:0] PC_STEP = 32'(INSTR_BYTES);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_pc;
        end else if (advance) begin
            pc <= pc + PC_STEP;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues single-outstanding imem requests and
// presents pc_o/instr_o to IF/ID. Define IF_MISALIGN_CHECK_EN to trap misaligned redirects.
module if_fetch_unit
  import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall_i,
    input  logic               redirect_i,
    input  logic [31:0]        redirect_pc_i,
    if_fetch_unit_if.master    imem,
    output logic [31:0]        pc_o,
    output logic [31:0]        instr_o,
    output logic               valid_o,
`ifdef IF_MISALIGN_CHECK_EN
    output logic               misalign_o,
`endif
    output fetch_state_e       fetch_state
);

    fetch_state_e state, state_n;
    logic         kill, kill_n;
    logic [31:0]  pc;
    logic [31:0]  target;
    logic         target_misaligned;
    logic         outstanding;
    logic         pend_after;
    logic         pc_advance;
    logic         out_load;
    logic         out_clear;

`ifdef IF_MISALIGN_CHECK_EN
    assign target            = redirect_pc_i;
    assign target_misaligned = (redirect_pc_i[1:0] != 2'b00);
`else
    assign target            = redirect_pc_i & ADDR_ALIGN_MASK;
    assign target_misaligned = 1'b0;
`endif

    if_pc_gen #(.RESET_PC(RESET_PC)) u_pc_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (redirect_i),
        .load_pc (target),
        .advance (pc_advance),
        .pc      (pc)
    );

    // A response is still owed to us if one was accepted earlier (WAIT, or ERR with
    // kill) and has not arrived this cycle, or if a request is granted right now.
    assign outstanding = (state == WAIT) || ((state == ERR) && kill);
    assign pend_after  = (outstanding && !imem.imem_rvalid_i) ||
                         ((state == REQ) && imem.imem_gnt_i);

    always_comb begin
        state_n    = state;
        kill_n     = kill;
        pc_advance = 1'b0;
        out_load   = 1'b0;
        out_clear  = 1'b0;
        if (redirect_i) begin
            out_clear = 1'b1;
            kill_n    = pend_after;
            if (target_misaligned) begin
                state_n = ERR;
            end else if (pend_after) begin
                state_n = WAIT;
            end else begin
                state_n = REQ;
            end
        end else begin
            case (state)
                REQ: begin
                    if (imem.imem_gnt_i) state_n = WAIT;
                end
                WAIT: begin
                    if (imem.imem_rvalid_i) begin
                        if (kill) begin
                            kill_n  = 1'b0;
                            state_n = REQ;
                        end else begin
                            out_load   = 1'b1;
                            pc_advance = 1'b1;
                            state_n    = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!stall_i) begin
                        out_clear = 1'b1;
                        state_n   = REQ;
                    end
                end
`ifdef IF_MISALIGN_CHECK_EN
                ERR: begin
                    if (kill && imem.imem_rvalid_i) kill_n = 1'b0;
                end
`endif
                default: state_n = REQ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= REQ;
            kill  <= 1'b0;
        end else begin
            state <= state_n;
            kill  <= kill_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_o <= 1'b0;
            pc_o    <= 32'h0;
            instr_o <= NOP_INSTR;
        end else if (out_clear) begin
            valid_o <= 1'b0;
            pc_o    <= 32'h0;
            instr_o <= NOP_INSTR;
        end else if (out_load) begin
            valid_o <= 1'b1;
            pc_o    <= pc;
            instr_o <= imem.imem_rdata_i;
        end
    end

`ifdef IF_MISALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_o <= 1'b0;
        end else if (redirect_i) begin
            misalign_o <= target_misaligned;
        end
    end
`endif

    assign imem.imem_req_o  = (state == REQ);
    assign imem.imem_addr_o = pc;
    assign fetch_state      = state;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed table-driven bench for if_fetch_unit; each record is one cycle's inputs
// and the outputs expected during that cycle. Honours IF_MISALIGN_CHECK_EN.
module tb_if_fetch_unit;
  import cpu_pkg::*;

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic        e_mis;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         stall_i = 1'b0;
  logic         redirect_i = 1'b0;
  logic [31:0]  redirect_pc_i = 32'h0;
  logic [31:0]  pc_o;
  logic [31:0]  instr_o;
  logic         valid_o;
  logic         misalign_o;
  fetch_state_e fetch_state;

  int checks = 0;
  int errors = 0;
  vec_t vq[$];
  logic [31:0] last_addr;

  if_fetch_unit_if imem_bus ();

  if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem          (imem_bus),
    .pc_o          (pc_o),
    .instr_o       (instr_o),
    .valid_o       (valid_o),
`ifdef IF_MISALIGN_CHECK_EN
    .misalign_o    (misalign_o),
`endif
    .fetch_state   (fetch_state)
  );

`ifndef IF_MISALIGN_CHECK_EN
  assign misalign_o = 1'b0;
`endif

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(
    input logic stall, input logic redir, input logic [31:0] rpc,
    input logic gnt, input logic rvalid, input logic [31:0] rdata,
    input logic e_req, input logic [31:0] e_addr, input logic e_valid,
    input logic [31:0] e_pc, input logic [31:0] e_instr, input logic e_mis);
    vec_t v;
    v.stall = stall;  v.redir = redir;   v.rpc = rpc;
    v.gnt = gnt;      v.rvalid = rvalid; v.rdata = rdata;
    v.e_req = e_req;  v.e_addr = e_addr; v.e_valid = e_valid;
    v.e_pc = e_pc;    v.e_instr = e_instr; v.e_mis = e_mis;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive at the falling edge, check mid-cycle, then advance one full cycle.
  task automatic apply(input vec_t v, input string nm);
    stall_i                = v.stall;
    redirect_i             = v.redir;
    redirect_pc_i          = v.rpc;
    imem_bus.imem_gnt_i    = v.gnt;
    imem_bus.imem_rvalid_i = v.rvalid;
    imem_bus.imem_rdata_i  = v.rdata;
    #1;
    chk({nm, " req"},   {31'h0, imem_bus.imem_req_o}, {31'h0, v.e_req});
    chk({nm, " addr"},  imem_bus.imem_addr_o, v.e_addr);
    chk({nm, " valid"}, {31'h0, valid_o}, {31'h0, v.e_valid});
    chk({nm, " pc"},    pc_o, v.e_pc);
    chk({nm, " instr"}, instr_o, v.e_instr);
`ifdef IF_MISALIGN_CHECK_EN
    chk({nm, " misalign"}, {31'h0, misalign_o}, {31'h0, v.e_mis});
`endif
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    imem_bus.imem_gnt_i    = 1'b0;
    imem_bus.imem_rvalid_i = 1'b0;
    imem_bus.imem_rdata_i  = 32'h0;

    //            st re rpc           gn rv rdata          req addr          v  pc            instr         mis
    vq.push_back(mk(0, 0, 32'h0,      1, 0, 32'h0,         1, 32'h0,         0, 32'h0,        32'h0,        0));
    vq.push_back(mk(0, 0, 32'h0,      0, 1, 32'h00500093,  0, 32'h0,         0, 32'h0,        32'h0,        0));
    vq.push_back(mk(0, 0, 32'h0,      0, 0, 32'h0,         0, 32'h4,         1, 32'h0,        32'h00500093, 0));
    vq.push_back(mk(0, 0, 32'h0,      1, 0, 32'h0,         1, 32'h4,         0, 32'h0,        32'h0,        0));
    vq.push_back(mk(0, 0, 32'h0,      0, 1, 32'h00100113,  0, 32'h4,         0, 32'h0,        32'h0,        0));
    for (int s = 0; s < 4; s++)
      vq.push_back(mk(1, 0, 32'h0,    0, 0, 32'h0,         0, 32'h8,         1, 32'h4,        32'h00100113, 0));
    vq.push_back(mk(0, 0, 32'h0,      0, 0, 32'h0,         0, 32'h8,         1, 32'h4,        32'h00100113, 0));
    vq.push_back(mk(0, 0, 32'h0,      1, 0, 32'h0,         1, 32'h8,         0, 32'h0,        32'h0,        0));
    vq.push_back(mk(0, 1, 32'h100,    0, 0, 32'h0,         0, 32'h8,         0, 32'h0,        32'h0,        0));
    vq.push_back(mk(0, 0, 32'h0,      0, 0, 32'h0,         0, 32'h100,       0, 32'h0,        32'h0,        0));
    vq.push_back(mk(0, 0, 32'h0,      0, 1, 32'hDEADBEEF,  0, 32'h100,       0, 32'h0,        32'h0,        0));
    vq.push_back(mk(0, 0, 32'h0,      0, 0, 32'h0,         1, 32'h100,       0, 32'h0,        32'h0,        0));
    vq.push_back(mk(0, 0, 32'h0,      1, 0, 32'h0,         1, 32'h100,       0, 32'h0,        32'h0,        0));
    vq.push_back(mk(0, 0, 32'h0,      0, 1, 32'h12345678,  0, 32'h100,       0, 32'h0,        32'h0,        0));
    vq.push_back(mk(0, 1, 32'hC,      0, 0, 32'h0,         0, 32'h104,       1, 32'h100,      32'h12345678, 0));
    vq.push_back(mk(0, 1, 32'h40,     1, 0, 32'h0,         1, 32'hC,         0, 32'h0,        32'h0,        0));
    vq.push_back(mk(0, 0, 32'h0,      0, 1, 32'hBAD0BAD0,  0, 32'h40,        0, 32'h0,        32'h0,        0));
    vq.push_back(mk(0, 0, 32'h0,      1, 0, 32'h0,         1, 32'h40,        0, 32'h0,        32'h0,        0));
    vq.push_back(mk(0, 0, 32'h0,      0, 1, 32'h00208233,  0, 32'h40,        0, 32'h0,        32'h0,        0));
    vq.push_back(mk(1, 1, 32'h80,     0, 0, 32'h0,         0, 32'h44,        1, 32'h40,       32'h00208233, 0));
    vq.push_back(mk(1, 0, 32'h0,      0, 0, 32'h0,         1, 32'h80,        0, 32'h0,        32'h0,        0));
    vq.push_back(mk(0, 0, 32'h0,      1, 0, 32'h0,         1, 32'h80,        0, 32'h0,        32'h0,        0));
    vq.push_back(mk(0, 0, 32'h0,      0, 0, 32'h0,         0, 32'h80,        0, 32'h0,        32'h0,        0));
    vq.push_back(mk(0, 0, 32'h0,      0, 1, 32'hCAFE0013,  0, 32'h80,        0, 32'h0,        32'h0,        0));
    vq.push_back(mk(0, 0, 32'h0,      0, 0, 32'h0,         0, 32'h84,        1, 32'h80,       32'hCAFE0013, 0));
    vq.push_back(mk(0, 0, 32'h0,      0, 1, 32'h11111111,  1, 32'h84,        0, 32'h0,        32'h0,        0));
    vq.push_back(mk(0, 0, 32'h0,      0, 0, 32'h0,         1, 32'h84,        0, 32'h0,        32'h0,        0));

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset valid", {31'h0, valid_o}, 32'h0);
    chk("reset pc",    pc_o, 32'h0);
    chk("reset instr", instr_o, 32'h0);
    chk("reset addr",  imem_bus.imem_addr_o, 32'h0);
    chk("reset misalign", {31'h0, misalign_o}, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) apply(vq[i], $sformatf("v%0d", i));

`ifdef IF_MISALIGN_CHECK_EN
    // Misaligned redirect coinciding with a grant: ERR absorbs the pending response.
    apply(mk(0, 1, 32'h102, 1, 0, 32'h0,      1, 32'h84,  0, 32'h0, 32'h0, 0), "mis0");
    apply(mk(0, 0, 32'h0,   0, 0, 32'h0,      0, 32'h102, 0, 32'h0, 32'h0, 1), "mis1");
    apply(mk(0, 0, 32'h0,   0, 1, 32'h5A5A,   0, 32'h102, 0, 32'h0, 32'h0, 1), "mis2");
    apply(mk(0, 0, 32'h0,   0, 0, 32'h0,      0, 32'h102, 0, 32'h0, 32'h0, 1), "mis3");
    apply(mk(0, 1, 32'h200, 0, 0, 32'h0,      0, 32'h102, 0, 32'h0, 32'h0, 1), "mis4");
    apply(mk(0, 0, 32'h0,   0, 0, 32'h0,      1, 32'h200, 0, 32'h0, 32'h0, 0), "mis5");
    last_addr = 32'h200;
`else
    // Low target bits are dropped without the misalign check.
    apply(mk(0, 1, 32'h133, 0, 0, 32'h0,      1, 32'h84,  0, 32'h0, 32'h0, 0), "aln0");
    apply(mk(0, 0, 32'h0,   0, 0, 32'h0,      1, 32'h130, 0, 32'h0, 32'h0, 0), "aln1");
    last_addr = 32'h130;
`endif

    // PC wraps modulo 2^32 after the last word.
    apply(mk(0, 1, 32'hFFFFFFFC, 0, 0, 32'h0, 1, last_addr,    0, 32'h0,        32'h0,        0), "wrap0");
    apply(mk(0, 0, 32'h0,        1, 0, 32'h0, 1, 32'hFFFFFFFC, 0, 32'h0,        32'h0,        0), "wrap1");
    apply(mk(0, 0, 32'h0,        0, 1, 32'h93, 0, 32'hFFFFFFFC, 0, 32'h0,       32'h0,        0), "wrap2");
    apply(mk(0, 0, 32'h0,        0, 0, 32'h0, 0, 32'h0,        1, 32'hFFFFFFFC, 32'h00000093, 0), "wrap3");
    apply(mk(0, 0, 32'h0,        1, 0, 32'h0, 1, 32'h0,        0, 32'h0,        32'h0,        0), "wrap4");

    // Reset while a response is pending; the late rvalid must be ignored.
    rst_n = 1'b0;
    #1;
    chk("midrst valid", {31'h0, valid_o}, 32'h0);
    chk("midrst addr",  imem_bus.imem_addr_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(mk(0, 0, 32'h0, 0, 1, 32'hFFFF0000, 1, 32'h0, 0, 32'h0, 32'h0, 0), "stray0");
    apply(mk(0, 0, 32'h0, 0, 0, 32'h0,        1, 32'h0, 0, 32'h0, 32'h0, 0), "stray1");
    apply(mk(0, 0, 32'h0, 1, 0, 32'h0,        1, 32'h0, 0, 32'h0, 32'h0, 0), "stray2");
    apply(mk(0, 0, 32'h0, 0, 1, 32'h00A00113, 0, 32'h0, 0, 32'h0, 32'h0, 0), "stray3");
    apply(mk(0, 0, 32'h0, 0, 0, 32'h0,        0, 32'h4, 1, 32'h0, 32'h00A00113, 0), "stray4");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction fetch stage that sits directly upstream of the IF/ID pipeline register. It owns the program counter and issues single-outstanding fetch requests to instruction memory over a req/gnt/rvalid handshake. It presents `pc_o`/`instr_o` to IF/ID, emitting zero bubbles while no instruction is available. It honours the hazard-unit stall and the branch/jump redirect from later stages.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `stall_i` input 1: downstream stall; the same signal drives IF/ID `IFstall`.
- `redirect_i` input 1: taken branch/jump, one-cycle pulse.
- `redirect_pc_i` input 32: redirect target.
- `imem_req_o` output 1: fetch request.
- `imem_addr_o` output 32: fetch address, equal to the internal PC.
- `imem_gnt_i` input 1: request accepted this cycle.
- `imem_rvalid_i` input 1: read data valid; arrives at least 1 cycle after the accepted grant.
- `imem_rdata_i` input 32: instruction word.
- `pc_o` output 32: PC of the presented instruction.
- `instr_o` output 32: presented instruction; 0 when `valid_o`=0.
- `valid_o` output 1: `pc_o`/`instr_o` hold a real instruction.
- `misalign_o` output 1: present only with `IF_MISALIGN_CHECK_EN`.

## Operation
- States:
  - REQ: `imem_req_o`=1.
  - WAIT: one request accepted, response pending.
  - HOLD: instruction presented.
  - ERR: exists only with the macro.
- REQ behaviour:
  - `imem_gnt_i`=1 moves to WAIT.
  - Otherwise stay in REQ.
  - The address may change while ungranted (redirect); instruction memory tolerates this.
- WAIT behaviour:
  - On `imem_rvalid_i` with `kill`=0: register `instr_o`=rdata, `pc_o`=PC, `valid_o`=1; PC <= PC+4 (mod 2^32); go to HOLD.
  - On `imem_rvalid_i` with `kill`=1: discard the data, clear `kill`, go to REQ.
- HOLD behaviour:
  - With `stall_i`=0, the instruction is consumed this cycle; next cycle `valid_o`=0, `pc_o`=`instr_o`=0, state REQ.
  - With `stall_i`=1, all outputs are held unchanged.
- Redirect has priority over stall and over responses:
  - PC <= `redirect_pc_i`.
  - Next cycle `valid_o`=0 and `pc_o`=`instr_o`=0.
  - Next state is REQ, except in WAIT.
- Redirect in WAIT without rvalid: set `kill`, stay in WAIT.
- Redirect in WAIT with rvalid in the same cycle: discard the data, go to REQ.
- Redirect in REQ coinciding with gnt: the request counts as accepted; go to WAIT with `kill`=1.
- Back-to-back redirects: the last one wins; `kill` stays set until one response has been discarded.
- At most one outstanding request; no request is issued in WAIT or HOLD.

## Timing
- Reset (async assert) sets: PC=`RESET_PC`, state=REQ, `valid_o`=0, `pc_o`=0, `instr_o`=0, `kill`=0, `misalign_o`=0.
- `imem_req_o` rises combinationally in the first cycle after deassert.
- Reset asserted mid-transaction abandons the pending response; a stray rvalid arriving after deassert in REQ is ignored.
- `imem_req_o` and `imem_addr_o` are combinational from state and PC; all other outputs are registered.
- Latency with zero-wait memory:
  - Cycle 0: req+gnt.
  - Cycle 1: rvalid.
  - Cycle 2: `valid_o`=1.
- Best-case throughput is 1 instruction per 3 cycles; stalls and memory waits add cycles 1:1.

## Configuration
- `IF_MISALIGN_CHECK_EN` defined:
  - A redirect target with [1:0]≠0 enters ERR: `imem_req_o`=0, `valid_o`=0, `misalign_o`=1, PC holds the raw target.
  - ERR exits only on an aligned redirect.
  - A response pending at entry to ERR is absorbed via `kill`.
- Macro not defined: no `misalign_o` port and no ERR state; target bits [1:0] are forced to 00.

## Structure
- Shared package `cpu_pkg` holds the fetch state enum (REQ/WAIT/HOLD/ERR), `NOP_INSTR`=32'h0, and `INSTR_BYTES`=4.
- One sub-module, `if_pc_gen`: the PC register plus next-PC mux (reset / redirect / +4 / hold), with async active-low reset.

## Test plan
- Reset release, memory with gnt same cycle and rvalid +1, rdata 32'h00500093 at 0x0, no stall:
  - `valid_o` in cycle 2 with `pc_o`=0, `instr_o`=32'h00500093.
  - Next request to 0x4 issued in cycle 3.
- Stall of 4 cycles in HOLD: `pc_o`/`instr_o` stable and `imem_req_o`=0 throughout; request to PC+4 on the first unstalled cycle +1.
- Redirect to 0x100 while WAIT for 0x8, rvalid 2 cycles later with 32'hDEADBEEF:
  - The word is never presented.
  - The next request is to 0x100.
- Redirect to 0x40 coinciding with gnt for 0xC: the response is discarded and the following request is to 0x40.
- Redirect to 0x80 in HOLD while `stall_i`=1: next cycle `valid_o`=0 and `instr_o`=0; request to 0x80.
- With the macro defined, redirect to 0x102 then redirect to 0x200:
  - After the first redirect: `misalign_o`=1 and no requests are issued.
  - After the second redirect: `misalign_o`=0 and a request to 0x200 is issued.
